dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Multi-cycle data-memory responder on the pipelined CPU's MEM-stage request interface.
- The MEM stage initiates word reads and writes. This block services each request after a programmable latency.
- While a request is in service it holds the pipeline with a stall signal, then returns read data with a valid strobe.
- Replaces the single-cycle data memory when slow-memory timing must be modelled.

Parameters:
- DEPTH_WORDS, 128, number of 32-bit words in storage; word index = addr_i[31:2].
- LATENCY, 3, service time in cycles, legal range 1..15; counter is 4 bits.

Ports:
- clk_i  input  1  clock, all state updates on rising edge.
- rst_i  input  1  synchronous, active-high reset.
- req_i  input  1  MEM-stage request; held stable by the CPU while stall_o=1.
- we_i  input  1  1=write (sw), 0=read (lw); sampled with req_i.
- addr_i  input  32  byte address from the ALU result.
- wdata_i  input  32  store data (rt value).
- stall_o  output  1  freeze PC, IF/ID, ID/EX and EX/MEM registers.
- rdata_o  output  32  load data, registered.
- rvalid_o  output  1  rdata_o valid for the current read, one cycle.
- err_o  output  1  request was misaligned or out of range, one cycle.

Behaviour:
Reset:
- rst_i=1 forces state IDLE, counter 0, latched request cleared, rdata_o=0, rvalid_o=0, err_o=0.
- Storage contents are not cleared.
- Reset mid-operation abandons the request; a pending write is never committed.

FSM states and transitions:
- IDLE
  - req_i=1 loads addr, we and wdata into holding registers and loads the counter with LATENCY-1.
  - Next state is BUSY if LATENCY>1, else DONE.
  - req_i=0 stays in IDLE.
- BUSY
  - Counter decrements each cycle; at 1 the next state is DONE.
  - req_i and all inputs are ignored; the latched copy is used.
  - req_i falling during BUSY does not cancel the access.
- DONE
  - Always returns to IDLE next cycle.
  - The held request is not re-accepted, because the pipeline advances on this edge.

stall_o (combinational):
- 1 when (state==IDLE and req_i) or state==BUSY; 0 in DONE and in idle IDLE.
- A request is therefore stalled for exactly LATENCY cycles. The pipeline advances on the edge ending the DONE cycle.

Operation at the edge entering DONE:
- Read: rdata_o <= mem[idx]; rvalid_o=1 during DONE.
- Write: mem[idx] <= wdata; rvalid_o=0; rdata_o keeps its previous value.

Error:
- err_o=1 in DONE if addr[1:0]!=0 or idx>=DEPTH_WORDS.
- On error, writes are suppressed, rdata_o <= 0 and rvalid_o=0.

Strobes:
- rvalid_o and err_o are 1 only in DONE and 0 otherwise.

Back-to-back requests:
- A new request is sampled in the IDLE cycle after DONE.
- Each access costs LATENCY+1 cycles of throughput: LATENCY stalled cycles plus one DONE cycle.
- Read-after-write to the same address returns the new data.

Test Plan:
1. LATENCY=3; reset, then mem[5] preloaded to 32'hDEADBEEF, read addr 0x14 -> stall_o=1 for 3 cycles, DONE cycle rdata_o=32'hDEADBEEF, rvalid_o=1, stall_o=0.
2. LATENCY=3; write addr 0x20 data 32'h12345678, next-IDLE read addr 0x20 -> second access returns 32'h12345678; each access stalls 3 cycles with a 1-cycle DONE gap between.
3. Misaligned write addr 0x22, then read addr 0x20 -> first DONE err_o=1 with no commit; read returns the old value; DONE on out-of-range read addr 4*128 gives err_o=1, rdata_o=0.
4. Assert rst_i in second BUSY cycle of a write to 0x40 -> next cycle IDLE, stall_o=0, all outputs 0; later read of 0x40 returns the pre-write value.
5. LATENCY=1; read requests in consecutive accepted slots -> stall_o high one cycle per access, alternating IDLE/DONE; rvalid_o pulses every second cycle.
6. Drop req_i and toggle addr_i during BUSY of a read to 0x08 -> DONE still returns mem[2]; no spurious second access follows.

Source files
------------

// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder
//   Multi-cycle data-memory responder for the MEM stage of the pipelined CPU.
//   Each word read/write request is serviced after LATENCY cycles. While the
//   request is in service the pipeline is frozen with stall_o. The access
//   completes in a one-cycle DONE state.
//
// Ports
//   clk_i       : clock, every state update happens on the rising edge
//   rst_i       : synchronous active-high reset
//   req_i       : MEM-stage request (held stable by the CPU while stalled)
//   we_i        : 1 = store word, 0 = load word (sampled with req_i)
//   addr_i      : byte address; word index = addr_i[31:2]
//   wdata_i     : store data
//   stall_o     : freeze PC, IF/ID, ID/EX and EX/MEM
//   rdata_o     : registered load data
//   rvalid_o    : rdata_o valid for the current load (DONE only)
//   err_o       : misaligned or out-of-range access (DONE only)
//   dbg_state_o : current FSM state (0 IDLE, 1 BUSY, 2 DONE)
//
// Handshake: the CPU raises req_i and keeps req_i, we_i, addr_i and wdata_i
// stable for as long as stall_o is 1. The request is latched in the IDLE
// cycle where it is first seen. The pipeline advances on the edge that ends
// the DONE cycle, where stall_o is 0, so the held request is never taken twice.
// ---------------------------------------------------------------------------
module dmem_responder #(
  parameter int DEPTH_WORDS = 128,
  parameter int LATENCY     = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        stall_o,
  output logic [31:0] rdata_o,
  output logic        rvalid_o,
  output logic        err_o,
  output logic [1:0]  dbg_state_o
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] lat_addr_q;
  logic [31:0] lat_wdata_q;
  logic        lat_we_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic        in_idle;
  logic        in_done;
  logic        go_done;
  logic [31:0] acc_addr;
  logic [31:0] acc_wdata;
  logic        acc_we;
  logic        acc_err;
  logic        lat_err;
  logic [IDX_W-1:0] acc_idx;

  function automatic logic addr_bad(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a[31:2] >= 30'(DEPTH_WORDS));
  endfunction

  // Next-state and counter logic. go_done marks the edge that enters DONE,
  // which is where the memory access itself is performed.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    go_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_i) begin
          cnt_d = 4'(LATENCY - 1);
          if (LATENCY > 1) begin
            state_d = BUSY;
          end else begin
            state_d = DONE;
            go_done = 1'b1;
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = DONE;
          go_done = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // With LATENCY=1 the access happens on the same edge that latches the
  // request, so the live inputs are used in IDLE and the latched copy after.
  assign in_idle   = (state_q == IDLE);
  assign in_done   = (state_q == DONE);
  assign acc_addr  = in_idle ? addr_i  : lat_addr_q;
  assign acc_wdata = in_idle ? wdata_i : lat_wdata_q;
  assign acc_we    = in_idle ? we_i    : lat_we_q;
  assign acc_err   = addr_bad(acc_addr);
  assign acc_idx   = acc_addr[IDX_W+1:2];
  assign lat_err   = addr_bad(lat_addr_q);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      lat_addr_q  <= 32'd0;
      lat_wdata_q <= 32'd0;
      lat_we_q    <= 1'b0;
      rdata_o     <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (in_idle && req_i) begin
        lat_addr_q  <= addr_i;
        lat_wdata_q <= wdata_i;
        lat_we_q    <= we_i;
      end
      if (go_done) begin
        if (acc_err) begin
          rdata_o <= 32'd0;
        end else if (!acc_we) begin
          rdata_o <= mem[acc_idx];
        end
      end
    end
  end

  // Storage survives reset; a write caught by reset is dropped.
  always_ff @(posedge clk_i) begin
    if (!rst_i && go_done && acc_we && !acc_err) begin
      mem[acc_idx] <= acc_wdata;
    end
  end

  assign stall_o     = (in_idle && req_i) || (state_q == BUSY);
  assign rvalid_o    = in_done && !lat_we_q && !lat_err;
  assign err_o       = in_done && lat_err;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_dmem_responder.sv
// ---------------------------------------------------------------------------
// tb_dmem_responder
//   Self-checking bench for dmem_responder. Two instances are driven
//   independently: index 0 with LATENCY=3 and index 1 with LATENCY=1.
//   Expected DONE-cycle outputs {err, rvalid, rdata} are computed from a
//   bench-side memory model when a request is driven and queued. A monitor
//   pops and compares them whenever an instance is in DONE.
// ---------------------------------------------------------------------------
module tb_dmem_responder;

  localparam int DEPTH = 128;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic        req_s   [2];
  logic        we_s    [2];
  logic [31:0] addr_s  [2];
  logic [31:0] wdata_s [2];
  logic        stall_s [2];
  logic [31:0] rdata_s [2];
  logic        rvalid_s[2];
  logic        err_s   [2];
  logic [1:0]  dbg_s   [2];

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(3)) u_dut3 (
    .clk_i(clk), .rst_i(rst), .req_i(req_s[0]), .we_i(we_s[0]),
    .addr_i(addr_s[0]), .wdata_i(wdata_s[0]), .stall_o(stall_s[0]),
    .rdata_o(rdata_s[0]), .rvalid_o(rvalid_s[0]), .err_o(err_s[0]),
    .dbg_state_o(dbg_s[0])
  );

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(1)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .req_i(req_s[1]), .we_i(we_s[1]),
    .addr_i(addr_s[1]), .wdata_i(wdata_s[1]), .stall_o(stall_s[1]),
    .rdata_o(rdata_s[1]), .rvalid_o(rvalid_s[1]), .err_o(err_s[1]),
    .dbg_state_o(dbg_s[1])
  );

  // ---------------- checking ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- model / scoreboard ----------------
  logic [31:0] model_mem [2][DEPTH];
  logic [31:0] model_rd  [2];
  logic [33:0] exp_q0[$];
  logic [33:0] exp_q1[$];
  bit          mon_en = 1'b0;

  function automatic logic is_bad(input logic [31:0] a);
    return (a[1:0] != 2'b00) || ((a >> 2) >= 32'(DEPTH));
  endfunction

  task automatic push_exp(input int inst, input logic we, input logic [31:0] a,
                          input logic [31:0] wd);
    logic        bad;
    logic [33:0] e;
    bad = is_bad(a);
    if (bad) model_rd[inst] = 32'd0;
    else if (we) model_mem[inst][a[8:2]] = wd;
    else model_rd[inst] = model_mem[inst][a[8:2]];
    e = {bad, (!we && !bad), model_rd[inst]};
    if (inst == 0) exp_q0.push_back(e);
    else exp_q1.push_back(e);
  endtask

  task automatic mon(input int inst);
    logic [33:0] e;
    int          sz;
    if (dbg_s[inst] == 2'd2) begin
      sz = (inst == 0) ? exp_q0.size() : exp_q1.size();
      if (sz == 0) begin
        check_eq("spurious_done", 64'(sz), 64'd1);
      end else begin
        e = (inst == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
        check_eq("done_out", {err_s[inst], rvalid_s[inst], rdata_s[inst]}, e);
        check_eq("done_stall", stall_s[inst], 0);
      end
    end else begin
      check_eq("strobe_outside_done", {rvalid_s[inst], err_s[inst]}, 0);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      mon(0);
      mon(1);
    end
  end

  // ---------------- driver ----------------
  // Called at a negedge in an IDLE cycle; returns at the negedge of the
  // following IDLE cycle, so consecutive calls are back-to-back requests.
  task automatic access(input int inst, input int lat, input logic we,
                        input logic [31:0] a, input logic [31:0] wd, input bit drop);
    int n_stall;
    int cyc;
    bit done;
    push_exp(inst, we, a, wd);
    req_s[inst]   = 1'b1;
    we_s[inst]    = we;
    addr_s[inst]  = a;
    wdata_s[inst] = wd;
    n_stall = 0;
    cyc     = 0;
    done    = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      #1;
      if (dbg_s[inst] == 2'd2) begin
        done = 1'b1;
      end else begin
        if (stall_s[inst]) n_stall++;
        if (drop && dbg_s[inst] == 2'd1) begin
          req_s[inst]   = 1'b0;
          addr_s[inst]  = $urandom;
          we_s[inst]    = 1'($urandom_range(0, 1));
          wdata_s[inst] = $urandom;
        end
        @(negedge clk);
        cyc++;
      end
    end
    check_eq("done_reached", done, 1);
    check_eq("stall_cycles", n_stall, lat);
    @(negedge clk);
    cyc++;
    check_eq("access_cycles", cyc, lat + 1);
    check_eq("idle_after", dbg_s[inst], 0);
    req_s[inst] = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] a;
    logic [31:0] d;
    for (int i = 0; i < 2; i++) begin
      req_s[i] = 1'b0; we_s[i] = 1'b0; addr_s[i] = 32'd0; wdata_s[i] = 32'd0;
      model_rd[i] = 32'd0;
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check_eq("reset_outs", {stall_s[i], rvalid_s[i], err_s[i], rdata_s[i]}, 0);
      check_eq("reset_state", dbg_s[i], 0);
    end
    rst = 1'b0;
    @(negedge clk);
    mon_en = 1'b1;

    // Plan 1: preload mem[5], then read 0x14
    access(0, 3, 1'b1, 32'h14, 32'hDEADBEEF, 1'b0);
    access(0, 3, 1'b0, 32'h14, 32'h0, 1'b0);

    // Plan 2: write then immediate read of the same word
    access(0, 3, 1'b1, 32'h20, 32'h12345678, 1'b0);
    access(0, 3, 1'b0, 32'h20, 32'h0, 1'b0);

    // Plan 3: misaligned write dropped, old value kept, out-of-range read
    access(0, 3, 1'b1, 32'h22, 32'hFFFF0000, 1'b0);
    access(0, 3, 1'b0, 32'h20, 32'h0, 1'b0);
    access(0, 3, 1'b0, 32'(4 * DEPTH), 32'h0, 1'b0);
    access(0, 3, 1'b1, 32'(4 * DEPTH + 4), 32'h5555AAAA, 1'b0);

    // Random in-range write/readback pairs, including the last word
    for (int i = 0; i < 6; i++) begin
      a = (i == 0) ? 32'(4 * (DEPTH - 1)) : 32'($urandom_range(0, DEPTH - 1)) << 2;
      d = $urandom;
      access(0, 3, 1'b1, a, d, 1'b0);
      access(0, 3, 1'b0, a, 32'h0, 1'b0);
    end

    // Plan 4: reset during the second BUSY cycle of a write to 0x40
    access(0, 3, 1'b1, 32'h40, 32'hA5A50001, 1'b0);
    req_s[0] = 1'b1; we_s[0] = 1'b1; addr_s[0] = 32'h40; wdata_s[0] = 32'hBAD0BAD0;
    @(negedge clk);
    check_eq("busy1_state", dbg_s[0], 1);
    @(negedge clk);
    check_eq("busy2_state", dbg_s[0], 1);
    rst = 1'b1;
    req_s[0] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_rd[0] = 32'd0;
    model_rd[1] = 32'd0;
    #1;
    check_eq("post_rst_state", dbg_s[0], 0);
    check_eq("post_rst_outs", {stall_s[0], rvalid_s[0], err_s[0], rdata_s[0]}, 0);
    check_eq("post_rst_outs_l1", {stall_s[1], rvalid_s[1], err_s[1], rdata_s[1]}, 0);
    @(negedge clk);
    access(0, 3, 1'b0, 32'h40, 32'h0, 1'b0);

    // Plan 5: LATENCY=1, writes then back-to-back reads
    for (int i = 0; i < 4; i++) begin
      access(1, 1, 1'b1, 32'(i * 4 + 16), $urandom, 1'b0);
    end
    for (int i = 0; i < 4; i++) begin
      access(1, 1, 1'b0, 32'(i * 4 + 16), 32'h0, 1'b0);
    end
    access(1, 1, 1'b1, 32'h3, 32'h77777777, 1'b0);
    access(1, 1, 1'b0, 32'(4 * DEPTH), 32'h0, 1'b0);
    access(1, 1, 1'b0, 32'h10, 32'h0, 1'b0);

    // Plan 6: req_i dropped and inputs scrambled while BUSY
    access(0, 3, 1'b1, 32'h08, 32'hC0FFEE02, 1'b0);
    access(0, 3, 1'b0, 32'h08, 32'h0, 1'b1);
    repeat (6) begin
      @(negedge clk);
      check_eq("no_restart_stall", stall_s[0], 0);
    end

    check_eq("q0_drained", 64'(exp_q0.size()), 0);
    check_eq("q1_drained", 64'(exp_q1.size()), 0);

    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
